// File: rtl/lemming_dig_arbiter_if.sv
// Bundle between the lemming FSMs and the dig-tool arbiter.
// master = lemming side (drives requests and ground sense),
// slave = arbiter side (drives grant, owner and status pulses).
interface lemming_dig_arbiter_if #(
  parameter int NUM_LEM = 4
);
  localparam int ID_W = $clog2(NUM_LEM);

  logic [NUM_LEM-1:0] dig_req;
  logic [NUM_LEM-1:0] ground;
  logic [NUM_LEM-1:0] dig_gnt;
  logic [ID_W-1:0]    owner_id;
  logic               busy;
  logic               done_pulse;
  logic               timeout_pulse;

  modport master (
    output dig_req, ground,
    input  dig_gnt, owner_id, busy, done_pulse, timeout_pulse
  );

  modport slave (
    input  dig_req, ground,
    output dig_gnt, owner_id, busy, done_pulse, timeout_pulse
  );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter sharing one digging tool among grounded lemmings, with dig timer and cooldown.
// Latency: grant registered 1 cycle after an eligible request is sampled; release 1 cycle after cause.
// No backpressure: requests are level-held; non-owners simply wait, the owner is never preempted.
module lemming_dig_arbiter #(
  parameter int NUM_LEM  = 4,
  parameter int DIG_MAX  = 16,
  parameter int COOLDOWN = 2
) (
  input logic                 clk,
  input logic                 areset,
  lemming_dig_arbiter_if.slave bus
);
  localparam int ID_W      = $clog2(NUM_LEM);
  localparam int CNT_W     = $clog2(DIG_MAX + 1);
  localparam int CC_W      = $clog2(COOLDOWN + 2);
  // COOL is unreachable when COOLDOWN==0; clamp so the compare constant stays non-negative.
  localparam int COOL_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIG,
    S_COOL
  } state_t;

  state_t             state;
  logic [NUM_LEM-1:0] gnt;
  logic [NUM_LEM-1:0] eligible;
  logic [NUM_LEM-1:0] pick_oh;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    owner_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick;
  logic               any_elig;
  logic [CNT_W-1:0]   cnt;
  logic [CC_W-1:0]    ccnt;
  logic               busy_q;
  logic               done_q;
  logic               to_q;
  logic               own_gnd;
  logic               own_req;
  logic               at_max;

  // Falling lemmings can never win the tool, whatever they request.
  always_comb eligible = bus.dig_req & bus.ground;

  // First eligible lemming scanning upward from the round-robin pointer, wrapping.
  always_comb begin
    pick     = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_LEM; i++) begin
      if (!any_elig && eligible[(int'(rr_ptr) + i) % NUM_LEM]) begin
        any_elig = 1'b1;
        pick     = ID_W'((int'(rr_ptr) + i) % NUM_LEM);
      end
    end
  end

  // One-hot form of the winner, plus the pointer value that follows the current owner.
  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    owner_nxt     = ID_W'((int'(owner) + 1) % NUM_LEM);
  end

  // Release conditions look only at the owner's own sampled inputs.
  always_comb begin
    own_gnd = bus.ground[owner];
    own_req = bus.dig_req[owner];
    at_max  = (cnt == CNT_W'(DIG_MAX - 1));
  end

  // Grant / dig / cooldown sequencer; all outputs registered here.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state  <= S_IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      ccnt   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            gnt    <= pick_oh;
            owner  <= pick;
            cnt    <= '0;
            state  <= S_DIG;
            busy_q <= 1'b1;
          end
        end
        S_DIG: begin
          if (!own_gnd || !own_req || at_max) begin
            gnt    <= '0;
            rr_ptr <= owner_nxt;
            ccnt   <= '0;
            // Break-through wins over timeout when both land on the final cycle.
            done_q <= !own_gnd;
            to_q   <= own_gnd && own_req && at_max;
            if (COOLDOWN == 0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              state  <= S_COOL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COOL: begin
          if (ccnt == CC_W'(COOL_LAST)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          gnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dig_gnt       = gnt;
  assign bus.owner_id      = owner;
  assign bus.busy          = busy_q;
  assign bus.done_pulse    = done_q;
  assign bus.timeout_pulse = to_q;
endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Directed bench for the dig-tool arbiter: per-cycle expectations are queued and
// checked one cycle later, 1 time unit after the rising edge.
module tb_lemming_dig_arbiter;
  logic clk;
  logic areset;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       to;
    int         own;
  } exp_t;

  exp_t exp_q[$];

  lemming_dig_arbiter_if #(.NUM_LEM(4)) bus ();

  lemming_dig_arbiter #(
    .NUM_LEM (4),
    .DIG_MAX (16),
    .COOLDOWN(2)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the coming edge, then pop and compare once it has happened.
  task automatic step(input string tag, input logic [3:0] g, input logic b,
                      input logic d, input logic t, input int own);
    exp_t e;
    e.tag = tag; e.gnt = g; e.busy = b; e.done = d; e.to = t; e.own = own;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "_gnt"},  32'(bus.dig_gnt),       32'(e.gnt));
    chk({e.tag, "_busy"}, 32'(bus.busy),          32'(e.busy));
    chk({e.tag, "_done"}, 32'(bus.done_pulse),    32'(e.done));
    chk({e.tag, "_to"},   32'(bus.timeout_pulse), 32'(e.to));
    if (e.gnt != 4'b0000) chk({e.tag, "_owner"}, 32'(bus.owner_id), 32'(e.own));
  endtask

  initial begin
    logic [3:0] oh;
    int         id;
    checks      = 0;
    errors      = 0;
    areset      = 1'b0;
    bus.dig_req = 4'b0000;
    bus.ground  = 4'b1111;

    // Reset state before any clock edge.
    #2;
    chk("rst_gnt",   32'(bus.dig_gnt),       32'h0);
    chk("rst_busy",  32'(bus.busy),          32'h0);
    chk("rst_owner", 32'(bus.owner_id),      32'h0);
    chk("rst_done",  32'(bus.done_pulse),    32'h0);
    chk("rst_to",    32'(bus.timeout_pulse), 32'h0);
    @(posedge clk);
    #1;
    areset = 1'b1;
    step("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // Single dig ended by break-through after 5 grant cycles.
    bus.dig_req = 4'b0100;
    for (int c = 0; c < 5; c++) step("single_gnt", 4'b0100, 1'b1, 1'b0, 1'b0, 2);
    bus.ground = 4'b1011;
    step("single_rel", 4'b0000, 1'b1, 1'b1, 1'b0, 0);
    bus.dig_req = 4'b0000;
    bus.ground  = 4'b1111;
    step("single_cool", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("single_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // Timeout: exactly 16 grant cycles, then the timeout pulse.
    bus.dig_req = 4'b0001;
    for (int c = 0; c < 16; c++) step("to_gnt", 4'b0001, 1'b1, 1'b0, 1'b0, 0);
    step("to_rel", 4'b0000, 1'b1, 1'b0, 1'b1, 0);
    bus.dig_req = 4'b0000;
    step("to_cool", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("to_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-dig: grant drops with no clock edge, no pulse.
    bus.dig_req = 4'b0010;
    step("mid_gnt", 4'b0010, 1'b1, 1'b0, 1'b0, 1);
    step("mid_gnt", 4'b0010, 1'b1, 1'b0, 1'b0, 1);
    #2;
    areset = 1'b0;
    #1;
    chk("arst_gnt",   32'(bus.dig_gnt),       32'h0);
    chk("arst_busy",  32'(bus.busy),          32'h0);
    chk("arst_owner", 32'(bus.owner_id),      32'h0);
    chk("arst_done",  32'(bus.done_pulse),    32'h0);
    bus.dig_req = 4'b0000;
    @(posedge clk);
    #1;
    chk("arst_hold_gnt", 32'(bus.dig_gnt), 32'h0);
    areset = 1'b1;
    step("arst_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // Round-robin with all requesting: 0,1,2,3,0, each running to timeout.
    bus.dig_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      oh = 4'b0001 << id;
      for (int c = 0; c < 16; c++) step("rr_gnt", oh, 1'b1, 1'b0, 1'b0, id);
      step("rr_rel", 4'b0000, 1'b1, 1'b0, 1'b1, 0);
      if (k == 4) bus.dig_req = 4'b0000;
      step("rr_cool", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
      step("rr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    end

    // Falling lemming 1 is never granted; abort by dropping the request gives no pulse.
    bus.dig_req = 4'b0011;
    bus.ground  = 4'b0001;
    for (int c = 0; c < 4; c++) step("inel_gnt", 4'b0001, 1'b1, 1'b0, 1'b0, 0);
    bus.dig_req = 4'b0010;
    step("inel_abort", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    bus.dig_req = 4'b0011;
    step("inel_cool", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("inel_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 0; c < 3; c++) step("inel_regnt", 4'b0001, 1'b1, 1'b0, 1'b0, 0);
    bus.dig_req = 4'b0000;
    step("inel_abort2", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    bus.ground = 4'b1111;
    step("inel_cool2", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("inel_idle2", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    // Break-through on the 16th grant cycle counts as done, not timeout.
    bus.dig_req = 4'b0100;
    for (int c = 0; c < 16; c++) step("sim_gnt", 4'b0100, 1'b1, 1'b0, 1'b0, 2);
    bus.ground = 4'b1011;
    step("sim_rel", 4'b0000, 1'b1, 1'b1, 1'b0, 0);
    bus.dig_req = 4'b0000;
    bus.ground  = 4'b1111;
    step("sim_cool", 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("sim_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
